// File: rtl/weight_addr_gen_if.sv
// Handshake bundle for weight_addr_gen: layer control inputs and
// address/index outputs, with modports for the generator and its consumer.
interface weight_addr_gen_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 4
);
    logic              i_start;
    logic              i_clear;
    logic              i_rd_en;
    logic [ADDR_W-1:0] i_base_addr;
    logic [ADDR_W-1:0] o_weight_addr;
    logic [CNT_W-1:0]  o_tap_cnt;
    logic [CNT_W-1:0]  o_ch_cnt;
    logic [CNT_W-1:0]  o_out_cnt;
    logic              o_busy;
    logic              o_last_tap;
    logic              o_done;

    modport slave (
        input  i_start, i_clear, i_rd_en, i_base_addr,
        output o_weight_addr, o_tap_cnt, o_ch_cnt, o_out_cnt,
               o_busy, o_last_tap, o_done
    );

    modport master (
        output i_start, i_clear, i_rd_en, i_base_addr,
        input  o_weight_addr, o_tap_cnt, o_ch_cnt, o_out_cnt,
               o_busy, o_last_tap, o_done
    );
endinterface

// File: rtl/weight_addr_gen.sv
// Convolution weight address generator: walks tap/channel/filter indices and
// a running address per rd_en. Define WEIGHT_ADDR_GEN_LOOP_EN for continuous mode.
module weight_addr_gen #(
    parameter int KERNEL_SIZE = 9,
    parameter int IN_CH       = 4,
    parameter int OUT_CH      = 14,
    parameter int ADDR_W      = 10,
    parameter int CNT_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    weight_addr_gen_if.slave bus
);
    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [CNT_W-1:0] TAP_MAX = CNT_W'(KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0] CH_MAX  = CNT_W'(IN_CH - 1);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(OUT_CH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_tap;
    logic [CNT_W-1:0]  r_ch;
    logic [CNT_W-1:0]  r_out;
    logic              r_done;

    logic w_tap_wrap;
    logic w_ch_wrap;
    logic w_out_wrap;
    logic w_final;

    assign w_tap_wrap = (r_tap == TAP_MAX);
    assign w_ch_wrap  = (r_ch == CH_MAX);
    assign w_out_wrap = (r_out == OUT_MAX);
    assign w_final    = w_tap_wrap && w_ch_wrap && w_out_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_addr  <= '0;
            r_tap   <= '0;
            r_ch    <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples pre-edge values; the default below makes done a single-cycle pulse.
            r_done <= 1'b0;
            if (bus.i_clear) begin
                r_state <= S_IDLE;
                r_addr  <= '0;
                r_tap   <= '0;
                r_ch    <= '0;
                r_out   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            r_state <= S_RUN;
                            r_base  <= bus.i_base_addr;
                            r_addr  <= bus.i_base_addr;
                            r_tap   <= '0;
                            r_ch    <= '0;
                            r_out   <= '0;
                        end
                    end
                    S_RUN: begin
                        if (bus.i_rd_en) begin
                            // Running address replaces the (out*IN_CH+ch)*KERNEL_SIZE+tap product.
                            if (w_final) begin
                                r_done <= 1'b1;
                                r_addr <= r_base;
`ifdef WEIGHT_ADDR_GEN_LOOP_EN
                                r_state <= S_RUN;
`else
                                r_state <= S_IDLE;
`endif
                            end else begin
                                r_addr <= r_addr + ADDR_W'(1);
                            end

                            if (w_tap_wrap) begin
                                r_tap <= '0;
                                if (w_ch_wrap) begin
                                    r_ch  <= '0;
                                    r_out <= w_out_wrap ? '0 : r_out + CNT_W'(1);
                                end else begin
                                    r_ch <= r_ch + CNT_W'(1);
                                end
                            end else begin
                                r_tap <= r_tap + CNT_W'(1);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_weight_addr = r_addr;
    assign bus.o_tap_cnt     = r_tap;
    assign bus.o_ch_cnt      = r_ch;
    assign bus.o_out_cnt     = r_out;
    assign bus.o_busy        = (r_state == S_RUN);
    assign bus.o_done        = r_done;
    assign bus.o_last_tap    = (r_state == S_RUN) && w_tap_wrap;
endmodule

// File: tb/tb_weight_addr_gen.sv
// Directed bench for weight_addr_gen (KERNEL_SIZE=3, IN_CH=2, OUT_CH=2);
// expectations follow WEIGHT_ADDR_GEN_LOOP_EN when it is defined.
module tb_weight_addr_gen;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 4;
`ifdef WEIGHT_ADDR_GEN_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct {
        logic             start;
        logic [ADDR_W-1:0] base;
        logic             rd;
        int               addr;
        int               tap;
        int               ch;
        int               outc;
        int               last;
        int               busy;
        int               done;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    vec_t vecs[15];

    weight_addr_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    weight_addr_gen #(
        .KERNEL_SIZE(3),
        .IN_CH(2),
        .OUT_CH(2),
        .ADDR_W(ADDR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int addr, input int tap,
                             input int ch, input int outc, input int last,
                             input int busy, input int done);
        check({tag, " addr"}, int'(bus.o_weight_addr), addr);
        check({tag, " tap"},  int'(bus.o_tap_cnt), tap);
        check({tag, " ch"},   int'(bus.o_ch_cnt), ch);
        check({tag, " out"},  int'(bus.o_out_cnt), outc);
        check({tag, " last"}, int'(bus.o_last_tap), last);
        check({tag, " busy"}, int'(bus.o_busy), busy);
        check({tag, " done"}, int'(bus.o_done), done);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input int base);
        bus.i_start     = 1'b1;
        bus.i_base_addr = ADDR_W'(base);
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic advance(input int n);
        bus.i_rd_en = 1'b1;
        for (int k = 0; k < n; k++) step();
        bus.i_rd_en = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        //             start base  rd  addr tap ch out last busy      done
        vecs[0]  = '{1'b0, 10'd0,   1'b1, 101, 1, 0, 0, 0, 1,         0};
        vecs[1]  = '{1'b1, 10'd300, 1'b0, 101, 1, 0, 0, 0, 1,         0};
        vecs[2]  = '{1'b0, 10'd0,   1'b0, 101, 1, 0, 0, 0, 1,         0};
        vecs[3]  = '{1'b0, 10'd0,   1'b1, 102, 2, 0, 0, 1, 1,         0};
        vecs[4]  = '{1'b0, 10'd0,   1'b1, 103, 0, 1, 0, 0, 1,         0};
        vecs[5]  = '{1'b0, 10'd0,   1'b1, 104, 1, 1, 0, 0, 1,         0};
        vecs[6]  = '{1'b0, 10'd0,   1'b1, 105, 2, 1, 0, 1, 1,         0};
        vecs[7]  = '{1'b0, 10'd0,   1'b1, 106, 0, 0, 1, 0, 1,         0};
        vecs[8]  = '{1'b0, 10'd0,   1'b1, 107, 1, 0, 1, 0, 1,         0};
        vecs[9]  = '{1'b0, 10'd0,   1'b1, 108, 2, 0, 1, 1, 1,         0};
        vecs[10] = '{1'b0, 10'd0,   1'b1, 109, 0, 1, 1, 0, 1,         0};
        vecs[11] = '{1'b0, 10'd0,   1'b1, 110, 1, 1, 1, 0, 1,         0};
        vecs[12] = '{1'b0, 10'd0,   1'b1, 111, 2, 1, 1, 1, 1,         0};
        vecs[13] = '{1'b0, 10'd0,   1'b1, 100, 0, 0, 0, 0, int'(LOOP), 1};
        vecs[14] = '{1'b0, 10'd0,   1'b0, 100, 0, 0, 0, 0, int'(LOOP), 0};

        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_clear     = 1'b0;
        bus.i_rd_en     = 1'b0;
        bus.i_base_addr = '0;
        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // rd_en in IDLE before any start is ignored.
        advance(1);
        check_all("idle_rd", 0, 0, 0, 0, 0, 0, 0);

        start_sweep(100);
        check_all("start", 100, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 15; i++) begin
            bus.i_start     = vecs[i].start;
            bus.i_base_addr = vecs[i].base;
            bus.i_rd_en     = vecs[i].rd;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].tap,
                      vecs[i].ch, vecs[i].outc, vecs[i].last,
                      vecs[i].busy, vecs[i].done);
        end
        bus.i_start = 1'b0;
        bus.i_rd_en = 1'b0;

        if (LOOP) begin
            // Second lap from the reloaded base; done only after its 12th read.
            bus.i_rd_en = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                step();
                check($sformatf("lap2_%0d addr", k), int'(bus.o_weight_addr), 100 + (k % 12));
                check($sformatf("lap2_%0d done", k), int'(bus.o_done), (k == 12) ? 1 : 0);
                check($sformatf("lap2_%0d busy", k), int'(bus.o_busy), 1);
            end
            bus.i_rd_en = 1'b0;
        end else begin
            advance(1);
            check_all("post_done_rd", 100, 0, 0, 0, 0, 0, 0);
        end

        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
        check_all("clear_any", 0, 0, 0, 0, 0, 0, 0);

        // Clear together with rd_en and start at address 105.
        start_sweep(100);
        advance(5);
        check_all("pre_clear", 105, 2, 1, 0, 1, 1, 0);
        bus.i_clear = 1'b1;
        bus.i_rd_en = 1'b1;
        bus.i_start = 1'b1;
        step();
        bus.i_clear = 1'b0;
        bus.i_start = 1'b0;
        check_all("clear_win", 0, 0, 0, 0, 0, 0, 0);
        step();
        check_all("clear_rd", 0, 0, 0, 0, 0, 0, 0);
        bus.i_rd_en = 1'b0;

        // Asynchronous reset mid-sweep at address 107.
        start_sweep(100);
        advance(7);
        check_all("pre_rst", 107, 1, 0, 1, 0, 1, 0);
        #3 rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        advance(2);
        check_all("rst_rd", 0, 0, 0, 0, 0, 0, 0);
        start_sweep(200);
        check_all("restart", 200, 0, 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
